// File: rtl/present_round_sequencer.sv
// Iterative toy-PRESENT engine (16-bit block, 20-bit key): one key_scheduler plus a
// single cipher_round reused over seven cycles, with a final whitening XOR.

package present_toy_pkg;
  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      4'hF: y = 4'h2;
      default: y = 4'h0;
    endcase
    return y;
  endfunction
endpackage

module key_scheduler (
  input  logic [19:0]      key_i,
  output logic [7:0][19:0] rk_o
);
  import present_toy_pkg::*;

  // k(i+1) = rotl13(k(i)), S-box on the top nibble, round index mixed into the low bits.
  always_comb begin
    logic [19:0] k;
    k       = key_i;
    rk_o    = '0;
    rk_o[0] = k;
    for (int i = 1; i < 8; i++) begin
      k        = {k[6:0], k[19:7]};
      k[19:16] = sbox4(k[19:16]);
      k[2:0]   = k[2:0] ^ 3'(i);
      rk_o[i]  = k;
    end
  end
endmodule

module cipher_round (
  input  logic [15:0] data_i,
  input  logic [19:0] rk_i,
  output logic [15:0] data_o
);
  import present_toy_pkg::*;

  // Key add (upper 16 bits, low nibble folded in), S-layer, then bit i -> 4*i mod 15.
  always_comb begin
    logic [15:0] x;
    logic [15:0] s;
    x = data_i ^ rk_i[19:4] ^ {12'h000, rk_i[3:0]};
    s = '0;
    for (int n = 0; n < 4; n++) begin
      s[4*n +: 4] = sbox4(x[4*n +: 4]);
    end
    data_o = '0;
    for (int i = 0; i < 15; i++) begin
      data_o[4'((4 * i) % 15)] = s[4'(i)];
    end
    data_o[15] = s[15];
  end
endmodule

module present_round_sequencer #(
  parameter int unsigned NUM_ROUNDS = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode,
  input  logic [15:0] in_text,
  input  logic [19:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_text,
  output logic        busy
);
  if (NUM_ROUNDS != 7) begin : g_num_rounds_check
    $error("present_round_sequencer: NUM_ROUNDS must be 7 (key schedule provides k0..k7)");
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROUND = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [2:0] LAST_CNT = 3'(NUM_ROUNDS - 1);

  state_t           state_q;
  logic [2:0]       cnt_q;
  logic [15:0]      data_q;
  logic [15:0]      out_text_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             mode_q;
  logic [19:0]      key_q;
  logic [7:0][19:0] rk_s;
  logic [2:0]       ksel_idx_s;
  logic [15:0]      wkey_s;
  logic [15:0]      round_out_s;

  key_scheduler u_keys (
    .key_i (key_q),
    .rk_o  (rk_s)
  );

  // Decrypt walks the schedule backwards and whitens with k0 instead of k7.
  assign ksel_idx_s = mode_q ? (3'd7 - cnt_q) : cnt_q;
  assign wkey_s     = mode_q ? rk_s[0][15:0] : rk_s[7][15:0];

  cipher_round u_round (
    .data_i (data_q),
    .rk_i   (rk_s[ksel_idx_s]),
    .data_o (round_out_s)
  );

  // Sequencer FSM with all handshake and status outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      data_q      <= 16'h0000;
      out_text_q  <= 16'h0000;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      mode_q      <= 1'b0;
      key_q       <= 20'h00000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            mode_q     <= in_mode;
            data_q     <= in_text;
            key_q      <= in_key;
            cnt_q      <= 3'd0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_ROUND;
          end
        end
        S_ROUND: begin
          data_q <= round_out_s;
          if (cnt_q == LAST_CNT) begin
            out_text_q  <= round_out_s ^ wkey_s;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_text  = out_text_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_present_round_sequencer.sv
// Bench for present_round_sequencer: vector table, scoreboard fed at accept time,
// and hand-written sequences for backpressure, dropped requests, reset and streaming.

module tb_present_round_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_mode = 1'b0;
  logic [15:0] in_text = 16'h0000;
  logic [19:0] in_key = 20'h00000;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_text;
  logic        busy;

  present_round_sequencer #(.NUM_ROUNDS(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_text   (in_text),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_text  (out_text),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic        prev_valid = 1'b0;
  logic [15:0] sb[$];

  // ---------------- golden model ----------------
  function automatic logic [3:0] m_sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
      4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
      4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
      4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
    endcase
  endfunction

  function automatic logic [15:0] m_round(input logic [15:0] d, input logic [19:0] rk);
    logic [15:0] x, s, o;
    x = d ^ (rk >> 4) ^ {12'h000, rk[3:0]};
    for (int n = 0; n < 4; n++) s[4*n +: 4] = m_sbox(x[4*n +: 4]);
    // Multiplying by 4 mod 15 is its own inverse, so output bit j comes from 4*j mod 15.
    for (int j = 0; j < 15; j++) o[j] = s[(4 * j) % 15];
    o[15] = s[15];
    return o;
  endfunction

  function automatic logic [15:0] golden(input logic mode, input logic [15:0] text,
                                         input logic [19:0] key);
    logic [19:0] ks [8];
    logic [19:0] r;
    logic [15:0] d;
    ks[0] = key;
    for (int i = 1; i < 8; i++) begin
      r = (ks[i-1] << 13) | (ks[i-1] >> 7);
      r[19:16] = m_sbox(r[19:16]);
      r[2:0] = r[2:0] ^ 3'(i);
      ks[i] = r;
    end
    d = text;
    for (int c = 0; c < 7; c++) d = m_round(d, mode ? ks[7 - c] : ks[c]);
    return d ^ (mode ? ks[0][15:0] : ks[7][15:0]);
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Observes the interface mid-cycle, ahead of the edge that acts on it.
  task automatic mon();
    if (rst) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) begin
        sb.push_back(golden(in_mode, in_text, in_key));
        acc_cyc = cyc + 1;
      end
      if (out_valid && !prev_valid) check("latency", 32'(cyc - acc_cyc), 32'd7);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL spurious_output: got %0h, expected no result", out_text);
        end else begin
          check("sb_result", {16'h0000, out_text}, {16'h0000, sb.pop_front()});
        end
      end
    end
    prev_valid = out_valid;
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic mode, input logic [15:0] text, input logic [19:0] key);
    logic done;
    in_mode  = mode;
    in_text  = text;
    in_key   = key;
    in_valid = 1'b1;
    done     = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      done = in_ready;
      tick();
    end
    in_valid = 1'b0;
    check("accept_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 40 && !out_valid; i++) tick();
    check("valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && !(in_ready && !out_valid); i++) tick();
    check("idle_timeout", {31'd0, in_ready && !out_valid}, 32'd1);
  endtask

  typedef struct {
    logic        mode;
    logic [15:0] text;
    logic [19:0] key;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [7];

  typedef struct {
    logic        mode;
    logic [15:0] text;
    logic [19:0] key;
  } blk_t;

  initial begin
    blk_t        blks [3];
    int          acc [3];
    int          n_acc;
    int          busy_cnt;
    logic [15:0] exp;

    vecs[0] = '{1'b0, 16'h1234, 20'hABCDE, 16'h0};
    vecs[1] = '{1'b1, 16'h1234, 20'hABCDE, 16'h0};
    vecs[2] = '{1'b0, 16'h0000, 20'h00000, 16'h0};
    vecs[3] = '{1'b1, 16'h0000, 20'h00000, 16'h0};
    vecs[4] = '{1'b0, 16'hFFFF, 20'hFFFFF, 16'h0};
    vecs[5] = '{1'b1, 16'hA5A5, 20'h12345, 16'h0};
    vecs[6] = '{1'b0, 16'h8001, 20'h80001, 16'h0};
    foreach (vecs[i]) vecs[i].exp = golden(vecs[i].mode, vecs[i].text, vecs[i].key);

    // Reset for two cycles, then check the idle state.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_text", {16'h0, out_text}, 32'd0);

    // Encrypt with busy-duration check.
    out_ready = 1'b1;
    send(1'b0, 16'h1234, 20'hABCDE);
    busy_cnt = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      busy_cnt++;
      tick();
    end
    check("busy_cycles", 32'(busy_cnt), 32'd8);
    wait_idle();

    // Vector table.
    foreach (vecs[i]) begin
      send(vecs[i].mode, vecs[i].text, vecs[i].key);
      wait_valid();
      check("vec_text", {16'h0, out_text}, {16'h0, vecs[i].exp});
      wait_idle();
    end

    // Backpressure: result must hold for 10 cycles, then a one-cycle ready drains it.
    out_ready = 1'b0;
    exp = golden(1'b0, 16'hC0DE, 20'h0F0F0);
    send(1'b0, 16'hC0DE, 20'h0F0F0);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_text", {16'h0, out_text}, {16'h0, exp});
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_drain_valid", {31'd0, out_valid}, 32'd0);
    check("bp_drain_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;

    // A request arriving mid-operation is dropped; in_key changes have no effect.
    send(1'b1, 16'hA5A5, 20'h12345);
    tick();
    tick();
    in_valid = 1'b1;
    in_text  = 16'hFFFF;
    in_key   = 20'hFFFFF;
    check("busy_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    in_valid = 1'b0;
    in_key   = 20'h55555;
    wait_valid();
    check("drop_text", {16'h0, out_text}, {16'h0, golden(1'b1, 16'hA5A5, 20'h12345)});
    wait_idle();
    check("drop_sb_empty", 32'(sb.size()), 32'd0);

    // Reset during round 4 aborts the block.
    send(1'b0, 16'h4321, 20'h13579);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_text", {16'h0, out_text}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (10) tick();
    check("midrst_no_output", {31'd0, out_valid}, 32'd0);
    send(1'b1, 16'h4321, 20'h13579);
    wait_valid();
    check("midrst_fresh", {16'h0, out_text}, {16'h0, golden(1'b1, 16'h4321, 20'h13579)});
    wait_idle();

    // Back-to-back: in_valid held high, next block presented after each accept.
    blks[0] = '{1'b0, 16'h0F0F, 20'hF0F0F};
    blks[1] = '{1'b1, 16'h7E57, 20'h2468A};
    blks[2] = '{1'b0, 16'hBEEF, 20'hCAFE1};
    n_acc    = 0;
    in_mode  = blks[0].mode;
    in_text  = blks[0].text;
    in_key   = blks[0].key;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && n_acc < 3; i++) begin
      if (in_ready) begin
        acc[n_acc] = cyc + 1;
        n_acc++;
        tick();
        if (n_acc < 3) begin
          in_mode = blks[n_acc].mode;
          in_text = blks[n_acc].text;
          in_key  = blks[n_acc].key;
        end
      end else begin
        tick();
      end
    end
    in_valid = 1'b0;
    check("b2b_accepts", 32'(n_acc), 32'd3);
    if (n_acc == 3) begin
      check("b2b_gap1", 32'(acc[1] - acc[0]), 32'd9);
      check("b2b_gap2", 32'(acc[2] - acc[1]), 32'd9);
    end
    wait_idle();
    repeat (3) tick();
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/present_round_sequencer.md
Name: present_round_sequencer

Overview:
Iterative controller for the 16-bit/20-bit-key toy PRESENT datapath. It instantiates one key_scheduler and time-shares a single cipher_round instance over 7 cycles per block, then applies the final whitening XOR. It supports encrypt and decrypt modes and uses valid/ready handshakes on both sides. This is the area-reduced alternative to the fully unrolled 7-instance pipeline.

Parameters:
NUM_ROUNDS, 7, round count; fixed by key_scheduler outputs k0..k7. Any other value is illegal and must be rejected by an elaboration-time check.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  request carries a valid block.
in_ready  output  1  sequencer can accept a block.
in_mode  input  1  0 = encrypt, 1 = decrypt; sampled at accept.
in_text  input  16  plaintext or ciphertext; sampled at accept.
in_key  input  20  master key; sampled at accept.
out_valid  output  1  out_text holds a finished result.
out_ready  input  1  consumer takes the result.
out_text  output  16  result block.
busy  output  1  high when state is not IDLE.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, round counter=0, data register=0, out_text=0, out_valid=0. busy=0 and in_ready=1 from the first cycle after reset.
- Reset aborts any in-flight block; its result is discarded and never presented.
- Latched on accept: mode, text, key. key_scheduler is driven combinationally from the latched key only. in_key changes after accept have no effect.
- FSM states:
  - IDLE: in_ready=1. The edge with in_valid&in_ready latches inputs, sets cnt=0, and moves to ROUND.
  - ROUND: in_ready=0. Each edge computes data <= cipher_round(data, ksel(cnt)) and increments cnt.
  - On the edge where cnt==6 (7th round): out_text <= round_out ^ wkey[15:0], out_valid <= 1, state moves to DONE.
  - DONE: out_valid=1. out_text and out_valid stay stable until an edge with out_ready=1. That edge clears out_valid and moves to IDLE. The next block is accepted no earlier than the following edge (no overlap).
- Key order:
  - Encrypt: ksel(cnt)=k(cnt), i.e. k0..k6; wkey=k7.
  - Decrypt: ksel(cnt)=k(7-cnt), i.e. k7..k1; wkey=k0.
- Width rules: round keys pass full 20 bits to cipher_round. Whitening uses bits [15:0] only. cnt is 3 bits and never wraps past 6 in ROUND.
- Latency: accept at edge E gives out_valid high after edge E+7. Minimum accept-to-accept spacing is 9 edges when out_ready is held high.
- in_valid while in_ready=0 is ignored; no buffering and no error.
- out_ready while out_valid=0 is ignored.
- rst together with in_valid: reset wins and nothing is accepted.
- rst together with out_ready in DONE: reset wins; outputs are 0 next cycle.
- Output is registered; no combinational path from in_* to out_*.

Test Plan:
1. Reset then encrypt: rst for 2 cycles, then in_mode=0, in_text=16'h1234, in_key=20'hABCDE, out_ready=1 -> out_valid rises exactly 7 edges after accept. out_text matches the golden model (k0..k6 chained through cipher_round, then XOR k7[15:0]). busy is high for 8 cycles.
2. Decrypt same stimulus with in_mode=1 -> out_text matches the golden model using k7..k1 then XOR k0[15:0]. Also check all-zero text and key: 16'h0000 / 20'h00000.
3. Backpressure: out_ready=0 for 10 cycles after out_valid -> out_text and out_valid stay constant. Raising out_ready for one cycle makes out_valid=0 and in_ready=1 on the next cycle.
4. Busy-input drop: pulse in_valid with 16'hFFFF during ROUND, and change in_key mid-operation -> that request is not accepted and the in-flight result is unaffected.
5. Reset mid-op: assert rst at round 4 -> next cycle out_valid=0, out_text=0, in_ready=1. A fresh block afterwards completes with the correct value and 7-edge latency.
6. Back-to-back: 3 blocks with out_ready=1 and in_valid held high -> accepts are spaced 9 edges apart and each result matches the golden model in order.
